// File: rtl/button_cmd_queue_if.sv
// Command queue bus: debounced button events and switch data in,
// one command at a time out over a valid/ack handshake.
interface button_cmd_queue_if #(
  parameter int NUM_BTN = 4,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 8
);
  localparam int ID_W  = $clog2(NUM_BTN);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_BTN-1:0] btn_evt;
  logic [DATA_W-1:0]  sw;
  logic               cmd_valid;
  logic [ID_W-1:0]    cmd_id;
  logic [DATA_W-1:0]  cmd_data;
  logic               cmd_ack;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               clr_ovf;

  // queue side
  modport master (
    input  btn_evt, sw, cmd_ack, clr_ovf,
    output cmd_valid, cmd_id, cmd_data, count, overflow
  );

  // producer/consumer side
  modport slave (
    output btn_evt, sw, cmd_ack, clr_ovf,
    input  cmd_valid, cmd_id, cmd_data, count, overflow
  );
endinterface

// File: rtl/button_cmd_queue.sv
// Collects one-cycle button release pulses into per-button pending bits,
// pushes them lowest-index first into a FIFO with a switch snapshot, and
// issues them one at a time through an IDLE/ISSUE/GAP output FSM.
module button_cmd_queue #(
  parameter int NUM_BTN = 4,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  button_cmd_queue_if.master bus
);
  localparam int ID_W  = $clog2(NUM_BTN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [NUM_BTN-1:0] pend, pend_nxt, clr, drop;
  logic [ID_W-1:0]    sel;
  logic               push, pop, full, valid;
  cmd_t               mem [DEPTH];
  cmd_t               cmd_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  state_t             state, state_nxt;

  assign full = (count == CNT_W'(DEPTH));
  assign push = (|pend) & ~full;

  // lowest-index pending button wins the push slot
  always_comb begin
    sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (pend[i]) sel = ID_W'(i);
  end

  // per-button pending latch; an event arriving as its own entry is
  // pushed re-arms the latch rather than counting as a drop
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      clr[i]      = push && (sel == ID_W'(i));
      drop[i]     = bus.btn_evt[i] & pend[i] & ~clr[i];
      pend_nxt[i] = bus.btn_evt[i] | (pend[i] & ~clr[i]);
    end
  end

  // pending bits register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;

  // FIFO storage, contents not reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{id: sel, data: bus.sw};

  // pointers and occupancy; push and pop in one cycle leave count alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // FSM next state; ack only matters while a command is presented
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      ISSUE:   if (bus.cmd_ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop only from IDLE with data available, valid from state
  always_comb begin
    pop   = 1'b0;
    valid = 1'b0;
    unique case (state)
      IDLE:    pop   = (count != '0);
      ISSUE:   valid = 1'b1;
      default: ;
    endcase
  end

  // output command register, loaded from the FIFO head on pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   cmd_q <= '0;
    else if (pop) cmd_q <= mem[rd_ptr];

  // sticky overflow; a new drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)           ovf <= 1'b0;
    else if (|drop)       ovf <= 1'b1;
    else if (bus.clr_ovf) ovf <= 1'b0;

  assign bus.cmd_valid = valid;
  assign bus.cmd_id    = cmd_q.id;
  assign bus.cmd_data  = cmd_q.data;
  assign bus.count     = count;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_button_cmd_queue.sv
// Directed bench for button_cmd_queue: latency, ordering, fill, overflow,
// stray acks and asynchronous reset.
module tb_button_cmd_queue;
  localparam int NB = 4;
  localparam int D  = 8;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   peak    = 0;

  button_cmd_queue_if #(.NUM_BTN(NB), .DEPTH(D), .DATA_W(DW)) bus();

  button_cmd_queue #(.NUM_BTN(NB), .DEPTH(D), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(bus.count) > peak) peak = int'(bus.count);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = (bus.cmd_valid === 1'b1);
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (bus.cmd_valid === 1'b1);
    end
  endtask

  task automatic pulse_ack();
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.cmd_valid); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
    n_tests++; if (bus.cmd_id !== 2'd0 || bus.cmd_data !== 8'h00) begin n_fail++; $display("FAIL reset_cmd got %0d/%h exp 0/00", bus.cmd_id, bus.cmd_data); end
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.sw = 8'hA5; bus.btn_evt = 4'b0100;
    tick();                                   // E1
    bus.btn_evt = 4'b0000;
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL single_e1 got v=%b c=%0d exp v=0 c=0", bus.cmd_valid, bus.count); end
    tick();                                   // E2
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL single_e2 got v=%b c=%0d exp v=0 c=1", bus.cmd_valid, bus.count); end
    tick();                                   // E3
    n_tests++; if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", bus.cmd_valid); end
    n_tests++; if (bus.cmd_id !== 2'd2 || bus.cmd_data !== 8'hA5) begin n_fail++; $display("FAIL single_cmd got %0d/%h exp 2/a5", bus.cmd_id, bus.cmd_data); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL single_count got %0d exp 0", bus.count); end
    pulse_ack();
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_low got %b exp 0", bus.cmd_valid); end
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL single_quiet got v=%b c=%0d exp v=0 c=0", bus.cmd_valid, bus.count); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_id [3] = '{2'd0, 2'd1, 2'd3};
    bit ok;
    peak = 0;
    bus.sw = 8'h3C; bus.btn_evt = 4'b1011;
    tick();
    bus.btn_evt = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL simul_timeout cmd %0d got no valid exp valid", k); end
      n_tests++; if (bus.cmd_id !== exp_id[k] || bus.cmd_data !== 8'h3C) begin n_fail++; $display("FAIL simul_cmd%0d got %0d/%h exp %0d/3c", k, bus.cmd_id, bus.cmd_data, exp_id[k]); end
      pulse_ack();
    end
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (peak != 2) begin n_fail++; $display("FAIL simul_peak got %0d exp 2", peak); end
    n_tests++; if (bus.overflow !== 1'b0 || bus.count !== 4'd0 || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL simul_end got o=%b c=%0d v=%b exp 0/0/0", bus.overflow, bus.count, bus.cmd_valid); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 12; k++) begin
      bus.sw = 8'h10 + 8'(k);
      bus.btn_evt = 4'(1 << (k % 4));
      tick();
      bus.btn_evt = 4'b0000;
      tick();
    end
    bus.sw = 8'hEE;
    tick(); tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd0 || bus.cmd_data !== 8'h10) begin n_fail++; $display("FAIL fill_issue got v=%b %0d/%h exp 1 0/10", bus.cmd_valid, bus.cmd_id, bus.cmd_data); end
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", bus.count); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got %b exp 0", bus.overflow); end
  endtask

  // runs with the FIFO full and button 1 already pending
  task automatic test_overflow();
    bus.btn_evt = 4'b0010; tick(); bus.btn_evt = 4'b0000; tick();
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_first got %b exp 1", bus.overflow); end
    bus.btn_evt = 4'b0010; tick(); bus.btn_evt = 4'b0000; tick();
    n_tests++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_second got o=%b c=%0d exp 1/8", bus.overflow, bus.count); end
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    bus.clr_ovf = 1'b1; bus.btn_evt = 4'b0010; tick(); bus.clr_ovf = 1'b0; bus.btn_evt = 4'b0000;
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", bus.overflow); end
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2 got %b exp 0", bus.overflow); end
  endtask

  task automatic test_drain();
    logic [1:0] eid;
    logic [7:0] edata;
    bit ok;
    for (int k = 0; k < 12; k++) begin
      if (k < 9) begin eid = 2'(k % 4);   edata = 8'h10 + 8'(k); end
      else       begin eid = 2'(k - 8);   edata = 8'hEE; end
      wait_valid(20, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL drain_timeout cmd %0d got no valid exp valid", k); end
      n_tests++; if (bus.cmd_id !== eid || bus.cmd_data !== edata) begin n_fail++; $display("FAIL drain_cmd%0d got %0d/%h exp %0d/%h", k, bus.cmd_id, bus.cmd_data, eid, edata); end
      pulse_ack();
    end
    for (int i = 0; i < 8; i++) tick();
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL drain_extra got v=%b c=%0d exp 0/0", bus.cmd_valid, bus.count); end
  endtask

  task automatic test_stray_ack();
    pulse_ack();                              // ack in IDLE, empty
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL stray_idle got v=%b c=%0d exp 0/0", bus.cmd_valid, bus.count); end
    bus.sw = 8'h77; bus.btn_evt = 4'b0011;
    tick(); bus.btn_evt = 4'b0000;            // E1
    tick(); tick();                           // E2, E3
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd0) begin n_fail++; $display("FAIL stray_first got v=%b id=%0d exp 1/0", bus.cmd_valid, bus.cmd_id); end
    bus.cmd_ack = 1'b1;
    tick();                                   // E4: GAP, ack still high
    tick();                                   // E5: IDLE, stray ack in GAP
    bus.cmd_ack = 1'b0;
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL stray_gap got v=%b c=%0d exp 0/1", bus.cmd_valid, bus.count); end
    tick();                                   // E6: pop second
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd1 || bus.count !== 4'd0) begin n_fail++; $display("FAIL stray_second got v=%b id=%0d c=%0d exp 1/1/0", bus.cmd_valid, bus.cmd_id, bus.count); end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL stray_hold got %b exp 1", bus.cmd_valid); end
    pulse_ack();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) begin
      bus.sw = 8'h40 + 8'(k);
      bus.btn_evt = 4'(1 << (k % 4));
      tick();
      bus.btn_evt = 4'b0000;
      tick();
    end
    tick();
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.count !== 4'd5) begin n_fail++; $display("FAIL rmid_setup got v=%b c=%0d exp 1/5", bus.cmd_valid, bus.count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_async got v=%b c=%0d o=%b exp 0/0/0", bus.cmd_valid, bus.count, bus.overflow); end
    #1 rst_n = 1'b1;
    tick();
    bus.sw = 8'h5A; bus.btn_evt = 4'b1000;
    tick(); bus.btn_evt = 4'b0000;            // E1
    n_tests++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e1 got %b exp 0", bus.cmd_valid); end
    tick();                                   // E2
    n_tests++; if (bus.count !== 4'd1 || bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e2 got c=%0d v=%b exp 1/0", bus.count, bus.cmd_valid); end
    tick();                                   // E3
    n_tests++; if (bus.cmd_valid !== 1'b1 || bus.cmd_id !== 2'd3 || bus.cmd_data !== 8'h5A || bus.count !== 4'd0) begin n_fail++; $display("FAIL rmid_cmd got v=%b %0d/%h c=%0d exp 1 3/5a 0", bus.cmd_valid, bus.cmd_id, bus.cmd_data, bus.count); end
    pulse_ack();
    for (int i = 0; i < 6; i++) tick();
    n_tests++; if (bus.cmd_valid !== 1'b0 || bus.count !== 4'd0) begin n_fail++; $display("FAIL rmid_stale got v=%b c=%0d exp 0/0", bus.cmd_valid, bus.count); end
  endtask

  initial begin
    bus.btn_evt = '0;
    bus.sw      = '0;
    bus.cmd_ack = 1'b0;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fill();
    test_overflow();
    test_drain();
    test_stray_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
